// File: rtl/sample_frame_packer.sv
// Packs 32-bit FIFO samples into framed UART byte streams:
// header, sequence number, sample bytes MSB first, then an XOR checksum.
module sample_frame_packer #(
  parameter int unsigned SAMPLES_PER_FRAME = 16,
  parameter logic [7:0]  HEADER_BYTE       = 8'hA5
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] FIFOData,
  input  logic        FIFODataValid,
  input  logic        FIFOEmpty,
  output logic        ReadyToRead,
  output logic [7:0]  DataOut,
  output logic        RequestToSend,
  input  logic        ReadyToSend,
  output logic        LatchData,
  output logic        Busy,
  output logic        FrameDone
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StSeq,
    StFetch,
    StWaitv,
    StBytes,
    StChk
  } state_e;

  localparam logic [7:0] LastSample = 8'(SAMPLES_PER_FRAME - 1);

  state_e      state_q, state_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  chk_q, chk_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  data_out;
  logic        rts;
  logic        latch;

  // Byte-offering states; DataOut depends only on registered state so it is
  // stable for as long as the transmitter stalls.
  assign rts   = (state_q == StHdr) || (state_q == StSeq) ||
                 (state_q == StBytes) || (state_q == StChk);
  assign latch = rts & ReadyToSend;

  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    cnt_d    = cnt_q;
    chk_d    = chk_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    data_out = 8'h00;
    case (state_q)
      StIdle: begin
        if (!FIFOEmpty) begin
          state_d = StHdr;
          cnt_d   = 8'h00;
          chk_d   = 8'h00;
        end
      end
      StHdr: begin
        data_out = HEADER_BYTE;
        if (latch) state_d = StSeq;
      end
      StSeq: begin
        data_out = seq_q;
        if (latch) begin
          chk_d   = chk_q ^ seq_q;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (!FIFOEmpty) state_d = StWaitv;
      end
      StWaitv: begin
        if (FIFODataValid) begin
          shift_d = FIFOData;
          idx_d   = 2'd0;
          state_d = StBytes;
        end
      end
      StBytes: begin
        data_out = shift_q[31:24];
        if (latch) begin
          chk_d   = chk_q ^ shift_q[31:24];
          shift_d = {shift_q[23:0], 8'h00};
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            cnt_d   = cnt_q + 8'd1;
            state_d = (cnt_q < LastSample) ? StFetch : StChk;
          end
        end
      end
      StChk: begin
        data_out = chk_q;
        if (latch) begin
          seq_d   = seq_q + 8'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StIdle;
      seq_q   <= 8'h00;
      cnt_q   <= 8'h00;
      chk_q   <= 8'h00;
      shift_q <= 32'h0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  // Pulses are masked during reset so a concurrent handshake cannot pop the FIFO.
  assign ReadyToRead   = (state_q == StFetch) && !FIFOEmpty && !Reset;
  assign FrameDone     = (state_q == StChk) && latch && !Reset;
  assign DataOut       = data_out;
  assign RequestToSend = rts;
  assign LatchData     = latch;
  assign Busy          = (state_q != StIdle);

endmodule

// File: doc/sample_frame_packer.md
SAMPLE_FRAME_PACKER -- requirements
Module: sample_frame_packer

Interface
REQ-001 SHALL have parameter SAMPLES_PER_FRAME, default 16, the number of 32-bit samples per frame (legal 1..255).
REQ-002 SHALL have parameter HEADER_BYTE, default 8'hA5, the frame sync byte.
REQ-003 SHALL have port Clock, input, 1, the single 100 MHz system clock; all logic is on its rising edge.
REQ-004 SHALL have port Reset, input, 1, a synchronous, active-high reset.
REQ-005 SHALL have port FIFOData, input, 32, the sample word from the capture FIFOs; it is valid when FIFODataValid is high.
REQ-006 SHALL have port FIFODataValid, input, 1, the FIFO read-data valid; it is high one or more cycles after ReadyToRead.
REQ-007 SHALL have port FIFOEmpty, input, 1, which is high when no sample can be read.
REQ-008 SHALL have port ReadyToRead, output, 1, the FIFO read enable; it is a single-cycle pulse.
REQ-009 SHALL have port DataOut, output, 8, the byte offered to the UART transmitter.
REQ-010 SHALL have port RequestToSend, output, 1, which is high while DataOut holds a byte awaiting transmission.
REQ-011 SHALL have port ReadyToSend, input, 1, which is high when the UART transmitter can accept a byte.
REQ-012 SHALL have port LatchData, output, 1, equal to RequestToSend & ReadyToSend (combinational); a byte is consumed in a cycle where it is high.
REQ-013 SHALL have port Busy, output, 1, which is high whenever the state is not IDLE.
REQ-014 SHALL have port FrameDone, output, 1, a one-cycle pulse in the cycle the checksum byte is consumed.

Function
REQ-015 SHALL send frame byte order: HEADER_BYTE, Seq[7:0], then per sample FIFOData[31:24],[23:16],[15:8],[7:0], then Checksum.
REQ-016 SHALL compute Checksum as the 8-bit XOR of every frame byte after the header (Seq plus all sample bytes).
REQ-017 SHALL implement FSM states IDLE, HDR, SEQ, FETCH, WAITV, BYTES, CHK.
REQ-018 IDLE -> HDR SHALL occur when FIFOEmpty is low; no frame SHALL start while FIFOEmpty is high.
REQ-019 HDR and SEQ SHALL assert RequestToSend with the respective byte and advance only on LatchData; SEQ -> FETCH.
REQ-020 FETCH SHALL pulse ReadyToRead for exactly one cycle when FIFOEmpty is low, then go to WAITV; while FIFOEmpty is high it SHALL hold in FETCH with ReadyToRead low, and the frame SHALL NOT be truncated.
REQ-021 WAITV SHALL capture FIFOData into a 32-bit shift register on the first cycle FIFODataValid is high, then go to BYTES; no second read SHALL be issued before that capture.
REQ-022 BYTES SHALL present shift register [31:24] and shift left 8 on each LatchData; after the 4th byte it SHALL go to FETCH if SampleCount < SAMPLES_PER_FRAME-1, else to CHK.
REQ-023 SampleCount SHALL be 8-bit, clear on entering HDR, and increment on the 4th byte of each sample.
REQ-024 CHK SHALL present Checksum; on LatchData it SHALL pulse FrameDone, increment Seq modulo 256 (255 -> 0), and go to IDLE.
REQ-025 DataOut and RequestToSend SHALL remain stable from assertion until LatchData; when ReadyToSend is low, the FSM SHALL stall indefinitely without loss.
REQ-026 RequestToSend SHALL be low in IDLE, FETCH and WAITV.
REQ-027 Back-to-back frames SHALL be permitted: CHK -> IDLE -> HDR costs exactly one IDLE cycle.
REQ-028 FIFODataValid arriving outside WAITV SHALL be ignored.

Reset
REQ-029 On Reset, the block SHALL force state IDLE, DataOut=8'h00, RequestToSend=0, ReadyToRead=0, FrameDone=0, Seq=0, SampleCount=0, Checksum=0 and shift register=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; the next frame SHALL start with HEADER_BYTE and Seq=0.
REQ-031 Reset SHALL take priority over every simultaneous handshake event.

Verification
REQ-032 SAMPLES_PER_FRAME=1, one sample 0x12345678, ReadyToSend tied high -> bytes A5 00 12 34 56 78 08, a single FrameDone pulse, exactly one ReadyToRead pulse.
REQ-033 Default parameters, 32 samples queued -> two frames with Seq 00 then 01, each 67 bytes, 32 ReadyToRead pulses in total.
REQ-034 FIFOEmpty raised for 50 cycles after the 5th sample -> hold in FETCH with RequestToSend low, then resume; the frame is still 67 bytes with correct checksum.
REQ-035 ReadyToSend toggled randomly (25% duty) -> byte stream identical to the ReadyToSend=1 run; DataOut never changes while RequestToSend=1 and LatchData=0.
REQ-036 256 frames sent -> Seq wraps to 00 on frame 257; Reset asserted during the 3rd sample byte -> outputs return to reset values next cycle, and the next frame header is followed by Seq 00.
